// File: rtl/logic_shift_unit_if.sv
// Request/response bundle for logic_shift_unit: operands and start from the
// requester, busy/done/result/err back from the unit.
interface logic_shift_unit_if #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 67,
    parameter int SHAMT_W = 7
);
    logic                start;
    logic [2:0]          op;
    logic [DATA_W-1:0]   x;
    logic [DATA_W-1:0]   y;
    logic [SHAMT_W-1:0]  shamt;
    logic                busy;
    logic                done;
    logic [ACC_W-1:0]    result;
    logic                err;

    modport master (
        output start, op, x, y, shamt,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, x, y, shamt,
        output busy, done, result, err
    );
endinterface

// File: rtl/logic_shift_unit.sv
// Bitwise logic and serial (one bit per clock) shift unit with a
// start/busy/done handshake and a registered ACC_W-bit result.
module logic_shift_unit #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 67,
    parameter int SHAMT_W = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_shift_unit_if.slave     bus
);
    localparam int CNT_W = $clog2(ACC_W + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SAR = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept_s;
    logic               is_shift_s;
    logic [CNT_W-1:0]   amt_s;

    function automatic logic [ACC_W-1:0] sign_extend(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] logic_eval(input logic [2:0] o,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (o)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            default: r = '0;
        endcase
        return {{(ACC_W-DATA_W){1'b0}}, r};
    endfunction

    function automatic logic [ACC_W-1:0] shift_step(input logic [2:0] o,
                                                     input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] r;
        case (o)
            OP_SHL:  r = {v[ACC_W-2:0], 1'b0};
            OP_SHR:  r = {1'b0, v[ACC_W-1:1]};
            OP_SAR:  r = {v[ACC_W-1], v[ACC_W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Amounts beyond the accumulator width saturate: further shifting changes nothing.
    function automatic logic [CNT_W-1:0] clamp_shamt(input logic [SHAMT_W-1:0] s);
        logic [CNT_W-1:0] r;
        if (32'(s) >= 32'(ACC_W)) begin
            r = CNT_W'(ACC_W);
        end else begin
            r = CNT_W'(s);
        end
        return r;
    endfunction

    assign accept_s   = bus.start & ~busy_q;
    assign is_shift_s = (bus.op == OP_SHL) | (bus.op == OP_SHR) | (bus.op == OP_SAR);
    assign amt_s      = clamp_shamt(bus.shamt);

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    op_d = bus.op;
                    if (is_shift_s && (amt_s != '0)) begin
                        acc_d   = sign_extend(bus.x);
                        cnt_d   = amt_s;
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        if (bus.op == OP_RSV) begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end else if (is_shift_s) begin
                            result_d = sign_extend(bus.x);
                        end else begin
                            result_d = logic_eval(bus.op, bus.x, bus.y);
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = shift_step(op_q, acc_q);
                cnt_d = cnt_q - CNT_W'(1);
                // A count of 1 (or a corrupted 0) finishes on this edge.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = acc_d;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_logic_shift_unit.sv
// Self-checking bench for logic_shift_unit: directed literal cases plus
// randomized traffic compared every cycle against a scheduling model.
module tb_logic_shift_unit;
    localparam int DATA_W  = 32;
    localparam int ACC_W   = 67;
    localparam int SHAMT_W = 7;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SAR = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    logic_shift_unit_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHAMT_W(SHAMT_W)) lsu_if ();

    logic_shift_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHAMT_W(SHAMT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lsu_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string name, input logic [ACC_W-1:0] act,
                             input logic [ACC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: shift amount actually applied (0 for non-shift ops).
    function automatic int ref_amt(input logic [2:0] o, input logic [SHAMT_W-1:0] s);
        int v;
        v = int'(s);
        if (o == OP_SHL || o == OP_SHR || o == OP_SAR)
            return (v >= ACC_W) ? ACC_W : v;
        return 0;
    endfunction

    // Reference: final result computed directly with whole-word operators.
    function automatic logic [ACC_W-1:0] ref_val(input logic [2:0] o,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b, input int n);
        logic signed [ACC_W-1:0] sx;
        logic [DATA_W-1:0] lr;
        sx = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
        case (o)
            OP_AND: begin lr = a & b; return ACC_W'(lr); end
            OP_OR:  begin lr = a | b; return ACC_W'(lr); end
            OP_XOR: begin lr = a ^ b; return ACC_W'(lr); end
            3'b011: begin lr = ~a;    return ACC_W'(lr); end
            OP_SHL: return sx << n;
            OP_SHR: return sx >> n;
            OP_SAR: return sx >>> n;
            default: return '0;
        endcase
    endfunction

    // Model state: expected outputs for the interval after the latest edge.
    logic             m_busy, m_done, m_err, m_pend, m_verr;
    logic [ACC_W-1:0] m_result, m_val;
    int               m_fin, edge_cnt, m_n;
    logic             m_acc;

    initial begin
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_verr = 1'b0;
        m_result = '0; m_val = '0; m_fin = 0; edge_cnt = 0; m_n = 0; m_acc = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0;
                m_result = '0; edge_cnt = 0;
            end else begin
                m_acc  = lsu_if.start && !m_busy;
                m_done = 1'b0;
                m_err  = 1'b0;
                if (m_pend && edge_cnt == m_fin) begin
                    m_done = 1'b1; m_result = m_val; m_err = m_verr;
                    m_pend = 1'b0; m_busy = 1'b0;
                end
                if (m_acc) begin
                    m_n = ref_amt(lsu_if.op, lsu_if.shamt);
                    m_val = ref_val(lsu_if.op, lsu_if.x, lsu_if.y, m_n);
                    if (m_n == 0) begin
                        m_done = 1'b1; m_result = m_val; m_err = (lsu_if.op == OP_RSV);
                        m_busy = 1'b0;
                    end else begin
                        m_pend = 1'b1; m_fin = edge_cnt + m_n; m_verr = 1'b0;
                        m_busy = 1'b1;
                    end
                end
                edge_cnt++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_vec("mon_busy",   ACC_W'(lsu_if.busy), ACC_W'(m_busy));
                check_vec("mon_done",   ACC_W'(lsu_if.done), ACC_W'(m_done));
                check_vec("mon_err",    ACC_W'(lsu_if.err),  ACC_W'(m_err));
                check_vec("mon_result", lsu_if.result,       m_result);
            end
        end
    end

    task automatic drive(input logic st, input logic [2:0] o, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [SHAMT_W-1:0] s);
        lsu_if.start = st;
        lsu_if.op    = o;
        lsu_if.x     = a;
        lsu_if.y     = b;
        lsu_if.shamt = s;
    endtask

    // Present one request for one edge, then scramble inputs after it is taken.
    task automatic issue(input logic [2:0] o, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [SHAMT_W-1:0] s);
        @(posedge clk); #1;
        drive(1'b1, o, a, b, s);
        @(posedge clk); #1;
        drive(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, SHAMT_W'($urandom));
    endtask

    task automatic wait_done(input int bound, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            lat++;
            if (lsu_if.busy) busy_cnt++;
            if (lsu_if.done) return;
        end
        n_cmp++;
        n_mis++;
        $display("FAIL done_timeout: got no done within %0d cycles expected done", bound);
    endtask

    int lat, bc;

    initial begin
        drive(1'b0, 3'b000, '0, '0, '0);
        rst_n = 1'b0;
        #12;
        check_vec("rst_busy",   ACC_W'(lsu_if.busy), '0);
        check_vec("rst_done",   ACC_W'(lsu_if.done), '0);
        check_vec("rst_err",    ACC_W'(lsu_if.err),  '0);
        check_vec("rst_result", lsu_if.result,       '0);
        #11 rst_n = 1'b1;

        issue(OP_AND, 32'h4001_0000, 32'h5005_0000, 7'd9);
        wait_done(10, lat, bc);
        check_int("and_lat", lat, 1);
        check_vec("and_res", lsu_if.result, 67'h0_0000_0000_4001_0000);
        check_vec("and_err", ACC_W'(lsu_if.err), '0);

        issue(OP_SHL, 32'h8000_0000, 32'h1234_5678, 7'd32);
        wait_done(100, lat, bc);
        check_int("shl32_lat", lat, 33);
        check_int("shl32_busy", bc, 32);
        check_vec("shl32_res", lsu_if.result, 67'h7_8000_0000_0000_0000);

        // SAR by 4 with a competing start while busy.
        issue(OP_SAR, 32'h8000_0000, 32'h0, 7'd4);
        @(negedge clk);
        check_vec("sar_busy1", ACC_W'(lsu_if.busy), ACC_W'(1'b1));
        @(posedge clk); #1;
        drive(1'b1, OP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd0);
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b0, OP_AND, 32'h0, 32'h0, 7'd0);
        wait_done(20, lat, bc);
        check_int("sar_lat", lat + 2, 5);
        check_vec("sar_res", lsu_if.result, 67'h7_FFFF_FFFF_F800_0000);

        // SHR by 0 followed by a back-to-back OR accepted in the done cycle.
        @(posedge clk); #1;
        drive(1'b1, OP_SHR, 32'h0000_0001, 32'h0, 7'd0);
        @(posedge clk); #1;
        drive(1'b1, OP_OR, 32'h0000_00F0, 32'h0000_000F, 7'd3);
        @(negedge clk);
        check_vec("shr0_done", ACC_W'(lsu_if.done), ACC_W'(1'b1));
        check_vec("shr0_res", lsu_if.result, 67'h0_0000_0000_0000_0001);
        @(posedge clk); #1;
        drive(1'b0, OP_AND, 32'h0, 32'h0, 7'd0);
        @(negedge clk);
        check_vec("b2b_done", ACC_W'(lsu_if.done), ACC_W'(1'b1));
        check_vec("b2b_res", lsu_if.result, 67'h0_0000_0000_0000_00FF);

        issue(OP_RSV, 32'hDEAD_BEEF, 32'h1357_9BDF, 7'd5);
        wait_done(10, lat, bc);
        check_int("rsv_lat", lat, 1);
        check_vec("rsv_err", ACC_W'(lsu_if.err), ACC_W'(1'b1));
        check_vec("rsv_res", lsu_if.result, '0);
        issue(OP_AND, 32'hFFFF_FFFF, 32'h8000_0001, 7'd0);
        wait_done(10, lat, bc);
        check_vec("rsv_clr_err", ACC_W'(lsu_if.err), '0);
        check_vec("rsv_clr_res", lsu_if.result, 67'h0_0000_0000_8000_0001);

        // Saturating shift amounts.
        issue(OP_SHR, 32'h8000_0000, 32'h0, 7'd100);
        wait_done(100, lat, bc);
        check_int("shr_sat_lat", lat, 68);
        check_vec("shr_sat_res", lsu_if.result, '0);
        issue(OP_SAR, 32'h8000_0000, 32'h0, 7'd127);
        wait_done(100, lat, bc);
        check_vec("sar_sat_res", lsu_if.result, 67'h7_FFFF_FFFF_FFFF_FFFF);

        // Reset during a long shift aborts it.
        issue(OP_SHL, 32'h0000_00FF, 32'h0, 7'd20);
        repeat (10) @(posedge clk);
        #2;
        check_vec("abort_busy_pre", ACC_W'(lsu_if.busy), ACC_W'(1'b1));
        rst_n = 1'b0;
        #1;
        check_vec("abort_busy", ACC_W'(lsu_if.busy), '0);
        check_vec("abort_done", ACC_W'(lsu_if.done), '0);
        check_vec("abort_res",  lsu_if.result,       '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        issue(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 7'd0);
        wait_done(10, lat, bc);
        check_int("xor_lat", lat, 1);
        check_vec("xor_res", lsu_if.result, 67'h0_0000_0000_F0F0_0F0F);

        // Random traffic, starts arriving regardless of busy.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? SHAMT_W'($urandom_range(60, 127))
                                              : SHAMT_W'($urandom_range(0, 12)));
            if (i % 150 == 75) begin
                #2 rst_n = 1'b0;
                #10 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        drive(1'b0, OP_AND, '0, '0, '0);
        repeat (80) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
